// File: rtl/vga_scanout_pkg.sv
// vga_scanout_pkg: shared VGA timing, framebuffer geometry and colour mapping
package vga_scanout_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int H_FP       = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BP       = 48;
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE   = 480;
    localparam int V_FP       = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 33;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int SCALE_LOG2 = 2;
    localparam int FB_W       = 160;
    localparam int FB_H       = 120;
    localparam int X_W        = 8;
    localparam int Y_W        = 7;
    localparam int CNT_W      = 10;

    localparam int COLOUR_W   = 3;
    localparam int R_BIT      = 2;
    localparam int G_BIT      = 1;
    localparam int B_BIT      = 0;

    typedef logic [COLOUR_W-1:0] colour_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_OFF = '0;

    function automatic rgb_t colour_to_rgb(input colour_t c);
        return '{r: {8{c[R_BIT]}}, g: {8{c[G_BIT]}}, b: {8{c[B_BIT]}}};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel enable, h/v scan counters, sync/active decode and frame_start
module vga_timing #(
    parameter int H_ACTIVE = vga_scanout_pkg::H_ACTIVE,
    parameter int H_FP     = vga_scanout_pkg::H_FP,
    parameter int H_SYNC   = vga_scanout_pkg::H_SYNC,
    parameter int H_BP     = vga_scanout_pkg::H_BP,
    parameter int V_ACTIVE = vga_scanout_pkg::V_ACTIVE,
    parameter int V_FP     = vga_scanout_pkg::V_FP,
    parameter int V_SYNC   = vga_scanout_pkg::V_SYNC,
    parameter int V_BP     = vga_scanout_pkg::V_BP
) (
    input  logic                                clk,
    input  logic                                resetn,
    output logic                                pix_en,
    output logic [vga_scanout_pkg::CNT_W-1:0]   h,
    output logic [vga_scanout_pkg::CNT_W-1:0]   v,
    output logic                                active,
    output logic                                hs_raw,
    output logic                                vs_raw,
    output logic                                frame_start
);
    import vga_scanout_pkg::*;

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic phase;
    logic h_last;
    logic v_last;

    assign pix_en = phase;
    assign h_last = h == CNT_W'(HT - 1);
    assign v_last = v == CNT_W'(VT - 1);
    assign active = (h < CNT_W'(H_ACTIVE)) && (v < CNT_W'(V_ACTIVE));
    assign hs_raw = !((h >= CNT_W'(H_ACTIVE + H_FP)) && (h < CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_raw = !((v >= CNT_W'(V_ACTIVE + V_FP)) && (v < CNT_W'(V_ACTIVE + V_FP + V_SYNC)));

    // divide the 50 MHz clock into a one-in-two pixel enable
    always_ff @(posedge clk or posedge resetn)
        if (resetn) phase <= 1'b0;
        else        phase <= ~phase;

    // scan counters step once per pixel period and wrap at the line/frame totals
    always_ff @(posedge clk or posedge resetn)
        if (resetn) begin
            h <= '0;
            v <= '0;
        end else if (pix_en) begin
            h <= h_last ? '0 : h + 1'b1;
            if (h_last) v <= v_last ? '0 : v + 1'b1;
        end

    // flag the edge that reloads (0,0); the reset-initialised origin is not flagged
    always_ff @(posedge clk or posedge resetn)
        if (resetn) frame_start <= 1'b0;
        else        frame_start <= pix_en && h_last && v_last;

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: framebuffer read-out with 4x4 upscaling onto 640x480@60 VGA pins
module vga_scanout #(
    parameter int H_ACTIVE   = vga_scanout_pkg::H_ACTIVE,
    parameter int H_FP       = vga_scanout_pkg::H_FP,
    parameter int H_SYNC     = vga_scanout_pkg::H_SYNC,
    parameter int H_BP       = vga_scanout_pkg::H_BP,
    parameter int V_ACTIVE   = vga_scanout_pkg::V_ACTIVE,
    parameter int V_FP       = vga_scanout_pkg::V_FP,
    parameter int V_SYNC     = vga_scanout_pkg::V_SYNC,
    parameter int V_BP       = vga_scanout_pkg::V_BP,
    parameter int SCALE_LOG2 = vga_scanout_pkg::SCALE_LOG2
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [7:0] rd_x,
    output logic [6:0] rd_y,
    output logic       rd_en,
    input  logic [2:0] rd_colour,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       vga_clk,
    output logic       frame_start
);
    import vga_scanout_pkg::*;

    logic             pix_en;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             active;
    logic             hs_raw;
    logic             vs_raw;
    rgb_t             rgb;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .resetn      (resetn),
        .pix_en      (pix_en),
        .h           (h),
        .v           (v),
        .active      (active),
        .hs_raw      (hs_raw),
        .vs_raw      (vs_raw),
        .frame_start (frame_start)
    );

    assign vga_clk    = ~pix_en;
    assign vga_sync_n = 1'b0;
    assign rd_x       = X_W'(h >> SCALE_LOG2);
    assign rd_y       = Y_W'(v >> SCALE_LOG2);
    assign rd_en      = active && !resetn;
    assign vga_r      = rgb.r;
    assign vga_g      = rgb.g;
    assign vga_b      = rgb.b;

    // capture colour and sync together at the end of the pixel period, when rd_colour is valid
    always_ff @(posedge clk or posedge resetn)
        if (resetn) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            rgb         <= RGB_OFF;
        end else if (pix_en) begin
            vga_hs      <= hs_raw;
            vga_vs      <= vs_raw;
            vga_blank_n <= active;
            rgb         <= active ? colour_to_rgb(rd_colour) : RGB_OFF;
        end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Read end of the pixel framebuffer.
- The datapath/control pair writes 160x120, 3-bit-colour pixels into the framebuffer through x/y/colour/writeEn.
- This block reads that buffer back through a synchronous read port.
- It generates 640x480@60 Hz VGA timing from the 50 MHz board clock, scaling each stored pixel 4x4, and drives the DAC/sync pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SCALE_LOG2, 2, log2 of screen pixels per stored pixel per axis

Ports:
clk  in  1  50 MHz system clock
resetn  in  1  asynchronous reset, active-high (1 = reset)
rd_x  out  8  framebuffer read column, 0..159
rd_y  out  7  framebuffer read row, 0..119
rd_en  out  1  read strobe; high while the scan position is in the active area
rd_colour  in  3  framebuffer data; valid exactly 1 clk after rd_x/rd_y
vga_r  out  8  red; 0xFF when colour bit2 = 1, else 0x00
vga_g  out  8  green; from colour bit1
vga_b  out  8  blue; from colour bit0
vga_hs  out  1  horizontal sync, active-low
vga_vs  out  1  vertical sync, active-low
vga_blank_n  out  1  1 during active video
vga_sync_n  out  1  tied 0
vga_clk  out  1  25 MHz pixel clock to the DAC
frame_start  out  1  one-clk pulse when scan wraps to (0,0)

Behaviour:
Pixel enable:
- phase register toggles every clk; pix_en = phase.
- vga_clk = ~phase, so the DAC rising edge falls mid-pixel period.

Counters:
- h counts 0..799 and v counts 0..524; both advance only on clk edges where pix_en = 1.
- When h = 799 it wraps to 0 and v increments.
- When v = 524 and h = 799, both wrap to 0.

Decode (combinational from the counters):
- active = (h < 640) and (v < 480).
- hs_raw = 0 when 656 <= h < 752.
- vs_raw = 0 when 490 <= v < 492.

Read port:
- rd_x = h >> SCALE_LOG2 and rd_y = v >> SCALE_LOG2; both are held for the full 2-clk pixel period.
- rd_en = active.
- Outside the active area, rd_x/rd_y are don't-care but stay stable within the period.

Pipeline:
- rd_colour is valid on the 2nd clk of the pixel period.
- On the next pix_en edge, the output registers capture, together:
  - {rgb from rd_colour, gated to 0 when !active}
  - hs_raw, vs_raw and active → vga_hs, vga_vs, vga_blank_n
- All outputs therefore lag the counters by exactly one pixel period (2 clks), and sync and colour stay aligned.

frame_start:
- Registered.
- High for one clk on the edge where the counters load (0,0).

Reset (async, while resetn = 1):
- h = 0, v = 0, phase = 0.
- vga_hs = 1, vga_vs = 1, vga_blank_n = 0, rgb = 0, frame_start = 0, rd_en = 0.

Boundary conditions:
- Reset asserted mid-frame: the next frame starts from (0,0) on release.
- First pix_en edge after release advances h to 1; no frame_start is emitted for the reset-initialised (0,0).
- Blanking always forces rgb to 0, whatever rd_colour is.
- rd_colour is never sampled on a clk where it is not valid.

Arithmetic:
- h: 10 bits. v: 10 bits.
- Comparisons are unsigned against parameter-derived totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP

Decomposition:
Shared package:
- Timing constants (active/porch/sync/total per axis) and framebuffer dimensions (160, 120).
- Colour width (3) and the colour-bit-to-channel mapping.
- The datapath/control write side uses the same constants.

Sub-module vga_timing:
- phase, h/v counters, sync/active decode, frame_start.
- vga_scanout adds the read-port mapping, the colour pipeline and the output registers.

Test Plan:
1. Reset: hold resetn = 1 for 5 clks mid-frame → vga_hs = 1, vga_vs = 1, blank_n = 0, rgb = 0, rd_en = 0. Release → first frame_start after exactly 840000 clks.
2. Line timing → vga_hs period = 1600 clks, low for 192 clks. blank_n high 1280 clks per visible line. vga_clk period = 2 clks.
3. Frame timing → vsync low for 3200 clks; frame_start period = 840000 clks; 480 blank_n-high lines per frame.
4. Address mapping:
   - at h = 4..7, v = 8..11 → rd_x = 1, rd_y = 2.
   - at h = 639, v = 479 → rd_x = 159, rd_y = 119.
   - rd_en drops at h = 640.
5. Colour pipeline: memory model returns rd_colour = rd_x[2:0] with 1-clk latency → vga_r/g/b show 0xFF/0x00 per bit for stored column 5 (R = FF, G = 00, B = FF), exactly 2 clks after the counters hit that column, aligned with blank_n.
6. Blanking: memory model drives rd_colour = 3'b111 constantly → rgb = 0 whenever blank_n = 0 (porches, sync, v >= 480), and FF/FF/FF otherwise.
